// File: rtl/comb_mem_d1_arbiter_pkg.sv
// Shared types and helpers for the comb_mem_d1 round-robin arbiter.
package comb_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        WAIT_WR = 2'd2,
        DONE    = 2'd3
    } arb_state_e;

    // A write is expected to finish one cycle after write_en; anything longer than this means done was lost.
    localparam int WAIT_WR_MAX = 4;

    // Index width for n requesters, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << w) < n) w++;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/comb_mem_d1_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after 'last', with wrap-around.
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [IDX_W-1:0]   winner,
    output logic               valid
);

    logic [IDX_W-1:0] idx;

    // Scanning offsets 1..NUM_REQ makes 'last' itself the lowest priority.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = IDX_W'((int'(last) + k) % NUM_REQ);
            if (!valid && req[idx]) begin
                winner = idx;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/comb_mem_d1_arbiter.sv
// Round-robin arbiter sharing one single-port comb_mem_d1 among NUM_REQ go/done requesters.
// Optional simulation checks are enabled with `define COMB_MEM_D1_ARBITER_CHECKS_EN.
module comb_mem_d1_arbiter
    import comb_mem_arb_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int WIDTH    = 32,
    parameter int SIZE     = 16,
    parameter int IDX_SIZE = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_go,
    input  logic [NUM_REQ-1:0]           req_write_en,
    input  logic [NUM_REQ*IDX_SIZE-1:0]  req_addr,
    input  logic [NUM_REQ*WIDTH-1:0]     req_write_data,
    output logic [WIDTH-1:0]             req_read_data,
    output logic [NUM_REQ-1:0]           req_done,
    output logic [IDX_SIZE-1:0]          mem_addr0,
    output logic [WIDTH-1:0]             mem_write_data,
    output logic                         mem_write_en,
    input  logic [WIDTH-1:0]             mem_read_data,
    input  logic                         mem_done,
    output logic [1:0]                   dbg_state
);

    localparam int GW = clog2_min1(NUM_REQ);

    // Handshake: a requester raises req_go[i] with its op/addr/data stable and holds it
    // until req_done[i] pulses for one cycle; req_read_data is valid only in that cycle.
    // Requests are sampled only while IDLE, so a go still high after done is a new request.

    arb_state_e         state_q, state_d;
    logic [GW-1:0]      grant_q, last_q, pick_idx;
    logic               pick_valid;
    logic [WIDTH-1:0]   rdata_q;
    logic [NUM_REQ-1:0] done_q;
    logic               granted_we;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (GW)
    ) u_pick (
        .req    (req_go),
        .last   (last_q),
        .winner (pick_idx),
        .valid  (pick_valid)
    );

    assign mem_addr0      = req_addr[int'(grant_q)*IDX_SIZE +: IDX_SIZE];
    assign mem_write_data = req_write_data[int'(grant_q)*WIDTH +: WIDTH];
    assign granted_we     = req_write_en[grant_q];
    assign req_read_data  = rdata_q;
    assign req_done       = done_q;
    assign dbg_state      = state_q;

    always_comb begin
        state_d      = state_q;
        mem_write_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_valid) state_d = ACCESS;
            end
            ACCESS: begin
                if (granted_we) begin
                    mem_write_en = 1'b1;
                    state_d      = WAIT_WR;
                end else begin
                    state_d = DONE;
                end
            end
            WAIT_WR: begin
                if (mem_done) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= GW'(NUM_REQ - 1);
            rdata_q <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= '0;
            if (state_q == IDLE && pick_valid) grant_q <= pick_idx;
            if (state_q == ACCESS && !granted_we) rdata_q <= mem_read_data;
            // Done is registered so it lines up with the DONE state cycle.
            if (state_d == DONE && state_q != DONE) done_q[grant_q] <= 1'b1;
            if (state_q == DONE) last_q <= grant_q;
        end
    end

`ifdef COMB_MEM_D1_ARBITER_CHECKS_EN
    int wait_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= 0;
        end else begin
            wait_cnt <= (state_q == WAIT_WR) ? wait_cnt + 1 : 0;
            if ((state_q == ACCESS || state_q == WAIT_WR) && !req_go[grant_q])
                $error("comb_mem_d1_arbiter: req_go[%0d] withdrawn before done", grant_q);
            if (state_q == ACCESS && int'(mem_addr0) >= SIZE)
                $error("comb_mem_d1_arbiter: address %0d out of range (SIZE=%0d)", mem_addr0, SIZE);
            if (state_q == WAIT_WR && wait_cnt >= WAIT_WR_MAX)
                $error("comb_mem_d1_arbiter: memory done not seen after write");
            if (!$onehot0(done_q))
                $error("comb_mem_d1_arbiter: req_done not one-hot");
        end
    end
`endif

endmodule

// File: tb/tb_comb_mem_d1_arbiter.sv
// Self-checking bench for comb_mem_d1_arbiter with NUM_REQ=4 and a behavioural comb_mem_d1.
module tb_comb_mem_d1_arbiter;
    import comb_mem_arb_pkg::*;

    localparam int NUM_REQ  = 4;
    localparam int WIDTH    = 32;
    localparam int SIZE     = 16;
    localparam int IDX_SIZE = 4;

    logic                        clk = 1'b0;
    logic                        reset;
    logic [NUM_REQ-1:0]          req_go, req_write_en, req_done;
    logic [NUM_REQ*IDX_SIZE-1:0] req_addr;
    logic [NUM_REQ*WIDTH-1:0]    req_write_data;
    logic [WIDTH-1:0]            req_read_data, mem_write_data, mem_read_data;
    logic [IDX_SIZE-1:0]         mem_addr0;
    logic                        mem_write_en, mem_done;
    logic [1:0]                  dbg_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    comb_mem_d1_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .WIDTH    (WIDTH),
        .SIZE     (SIZE),
        .IDX_SIZE (IDX_SIZE)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_go         (req_go),
        .req_write_en   (req_write_en),
        .req_addr       (req_addr),
        .req_write_data (req_write_data),
        .req_read_data  (req_read_data),
        .req_done       (req_done),
        .mem_addr0      (mem_addr0),
        .mem_write_data (mem_write_data),
        .mem_write_en   (mem_write_en),
        .mem_read_data  (mem_read_data),
        .mem_done       (mem_done),
        .dbg_state      (dbg_state)
    );

    // Known memory image restored on every reset; address 5 holds the read pattern.
    function automatic logic [WIDTH-1:0] init_val(input int i);
        return (i == 5) ? 32'hDEADBEEF : 32'h1000_0000 + 32'(i * 17);
    endfunction

    // comb_mem_d1: combinational read, write on posedge, done one cycle after write_en.
    logic [WIDTH-1:0] mem [SIZE];
    assign mem_read_data = mem[mem_addr0];

    always @(posedge clk) begin
        if (reset) begin
            mem_done <= 1'b0;
            for (int i = 0; i < SIZE; i++) mem[i] <= init_val(i);
        end else begin
            mem_done <= mem_write_en;
            if (mem_write_en) mem[mem_addr0] <= mem_write_data;
        end
    end

    typedef struct {
        int               r;
        logic             we;
        logic [IDX_SIZE-1:0] addr;
        logic [WIDTH-1:0] data;
        int               exp_lat;
        logic [WIDTH-1:0] exp_rd;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive_req(input int r, input logic we, input logic [IDX_SIZE-1:0] addr,
                             input logic [WIDTH-1:0] data);
        req_go[r]                          = 1'b1;
        req_write_en[r]                    = we;
        req_addr[r*IDX_SIZE +: IDX_SIZE]   = addr;
        req_write_data[r*WIDTH +: WIDTH]   = data;
    endtask

    task automatic apply_reset();
        reset        = 1'b1;
        req_go       = '0;
        req_write_en = '0;
        repeat (2) step();
        reset = 1'b0;
    endtask

    // Round-robin rule: first set request after the previous winner, wrapping.
    function automatic int rr_expect(input logic [NUM_REQ-1:0] v, input int last);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
        end
        return -1;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        int lat, wec;
        bit got;
        lat = 0;
        wec = 0;
        got = 0;
        drive_req(v.r, v.we, v.addr, v.data);
        for (int c = 0; c < 20 && !got; c++) begin
            step();
            lat++;
            if (mem_write_en) wec++;
            if (req_done != '0) got = 1;
        end
        chk({tag, " done_seen"}, 64'(got), 64'd1);
        if (got) begin
            chk({tag, " done_vec"}, 64'(req_done), 64'(1 << v.r));
            chk({tag, " latency"}, 64'(lat), 64'(v.exp_lat));
            chk({tag, " write_en_cycles"}, 64'(wec), 64'(v.we));
            if (!v.we) chk({tag, " read_data"}, 64'(req_read_data), 64'(v.exp_rd));
        end
        req_go[v.r] = 1'b0;
        step();
        chk({tag, " done_clear"}, 64'(req_done), 64'd0);
    endtask

    task automatic run_contention();
        int n, prev;
        logic [WIDTH-1:0] exp_rd;
        reset  = 1'b1;
        req_go = '0;
        repeat (2) step();
        drive_req(0, 1'b0, 4'd5, '0);
        drive_req(1, 1'b0, 4'd3, '0);
        reset = 1'b0;
        n = 0;
        prev = -100;
        for (int c = 0; c < 40 && n < 6; c++) begin
            step();
            if (req_done != '0) begin
                exp_rd = (n % 2 == 0) ? 32'hDEADBEEF : 32'h1000_0033;
                chk("contention order", 64'(req_done), 64'(1 << (n % 2)));
                chk("contention rdata", 64'(req_read_data), 64'(exp_rd));
                if (n > 0) chk("contention gap>=3", 64'(c - prev >= 3), 64'd1);
                prev = c;
                n++;
                if (n == 6) req_go = '0;
            end
        end
        chk("contention count", 64'(n), 64'd6);
        req_go = '0;
        repeat (5) step();
    endtask

    task automatic run_wrap();
        int order[3];
        int n;
        vec_t pre;
        order = '{1, 2, 0};
        apply_reset();
        pre = '{3, 1'b0, 4'd1, 32'h0, 2, 32'h1000_0011};
        run_vec(pre, "wrap pre");
        drive_req(1, 1'b0, 4'd2, '0);
        drive_req(2, 1'b0, 4'd4, '0);
        n = 0;
        for (int c = 0; c < 40 && n < 3; c++) begin
            step();
            if (req_done != '0) begin
                chk("wrap order", 64'(req_done), 64'(1 << order[n]));
                req_go[order[n]] = 1'b0;
                n++;
            end
            if (c == 0) drive_req(0, 1'b0, 4'd6, '0);
        end
        chk("wrap count", 64'(n), 64'd3);
        req_go = '0;
        repeat (3) step();
    endtask

    task automatic run_reset_mid_write();
        bit got;
        int cnt;
        vec_t post;
        apply_reset();
        drive_req(2, 1'b1, 4'd7, 32'h55AA_55AA);
        got = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            step();
            if (dbg_state == WAIT_WR) got = 1;
        end
        chk("abort reached WAIT_WR", 64'(got), 64'd1);
        reset  = 1'b1;
        req_go = '0;
        step();
        chk("abort state idle", 64'(dbg_state), 64'(IDLE));
        chk("abort done low", 64'(req_done), 64'd0);
        reset = 1'b0;
        cnt = 0;
        repeat (6) begin
            step();
            if (req_done != '0) cnt++;
        end
        chk("abort no stray done", 64'(cnt), 64'd0);
        post = '{2, 1'b0, 4'd7, 32'h0, 2, 32'h1000_0077};
        run_vec(post, "post-abort read");
    endtask

    task automatic run_random();
        logic [NUM_REQ-1:0] hist[$];
        logic [WIDTH-1:0]   shadow[SIZE];
        logic [NUM_REQ-1:0] dropped;
        int raised[NUM_REQ];
        int last_m, prev_done, idx, k, exp_w;
        logic we;
        logic [IDX_SIZE-1:0] addr;
        logic [WIDTH-1:0] data;

        apply_reset();
        for (int i = 0; i < SIZE; i++) shadow[i] = init_val(i);
        for (int i = 0; i < NUM_REQ; i++) raised[i] = 0;
        last_m    = NUM_REQ - 1;
        prev_done = -100;

        for (int t = 0; t < 800; t++) begin
            step();
            dropped = '0;
            if (req_done != '0) begin
                chk("rand done onehot", 64'($onehot(req_done)), 64'd1);
                idx = -1;
                for (int i = 0; i < NUM_REQ; i++) if (req_done[i]) idx = i;
                if (idx >= 0 && req_go[idx]) begin
                    we    = req_write_en[idx];
                    addr  = req_addr[idx*IDX_SIZE +: IDX_SIZE];
                    data  = req_write_data[idx*WIDTH +: WIDTH];
                    k     = t - (we ? 3 : 2);
                    exp_w = (k >= 0) ? rr_expect(hist[k], last_m) : -1;
                    chk("rand winner", 64'(idx), 64'(exp_w));
                    chk("rand gap>=3", 64'(t - prev_done >= 3), 64'd1);
                    chk("rand wait bound", 64'(t - raised[idx] <= 30), 64'd1);
                    if (we) shadow[addr] = data;
                    else chk("rand read data", 64'(req_read_data), 64'(shadow[addr]));
                    last_m    = idx;
                    prev_done = t;
                    req_go[idx]  = 1'b0;
                    dropped[idx] = 1'b1;
                end else begin
                    checks++;
                    errors++;
                    $display("FAIL rand unrequested done: got %0h expected a pending requester", req_done);
                end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_go[i] && t - raised[i] > 40) begin
                    checks++;
                    errors++;
                    $display("FAIL rand starved: requester %0d waited %0d cycles, required <= 40", i, t - raised[i]);
                    req_go[i] = 1'b0;
                end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req_go[i] && !dropped[i] && $urandom_range(0, 3) == 0) begin
                    drive_req(i, 1'($urandom_range(0, 1)), 4'($urandom_range(0, SIZE - 1)), $urandom);
                    raised[i] = t;
                end
            end
            hist.push_back(req_go);
        end
        req_go = '0;
        repeat (6) step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, 1'b0, 4'd5,  32'h0,        2, 32'hDEADBEEF};
        vecs[1] = '{1, 1'b1, 4'd3,  32'h0000_1234, 3, 32'h0};
        vecs[2] = '{2, 1'b0, 4'd3,  32'h0,        2, 32'h0000_1234};
        vecs[3] = '{3, 1'b1, 4'd15, 32'hCAFE_F00D, 3, 32'h0};
        vecs[4] = '{0, 1'b0, 4'd15, 32'h0,        2, 32'hCAFE_F00D};
        vecs[5] = '{3, 1'b0, 4'd0,  32'h0,        2, 32'h1000_0000};
        vecs[6] = '{1, 1'b1, 4'd0,  32'hFFFF_FFFF, 3, 32'h0};
        vecs[7] = '{2, 1'b0, 4'd0,  32'h0,        2, 32'hFFFF_FFFF};
        vecs[8] = '{1, 1'b0, 4'd1,  32'h0,        2, 32'h1000_0011};

        reset          = 1'b1;
        req_go         = '0;
        req_write_en   = '0;
        req_addr       = '0;
        req_write_data = '0;
        repeat (2) step();
        chk("reset state", 64'(dbg_state), 64'(IDLE));
        chk("reset done", 64'(req_done), 64'd0);
        chk("reset write_en", 64'(mem_write_en), 64'd0);
        chk("reset read_data", 64'(req_read_data), 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        run_contention();
        run_wrap();
        run_reset_mid_write();
        run_random();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/comb_mem_d1_arbiter.md
Name: comb_mem_d1_arbiter

Overview:
- Round-robin arbiter that lets NUM_REQ requesters share one single-port comb_mem_d1 instance.
- Each requester uses the go/done handshake.
- Sits between per-group memory accesses and the shared memory primitive.
- Serialises the accesses, holds the granted requester's address and data, and returns the read data and a done pulse to that requester.

Parameters:
NUM_REQ, 2, number of requesters (2..16)
WIDTH, 32, memory data width
SIZE, 16, memory depth (used only by the optional checks)
IDX_SIZE, 4, memory address width

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
req_go  input  NUM_REQ  per-requester request; held high until that requester's done
req_write_en  input  NUM_REQ  per-requester op select: 1=write, 0=read
req_addr  input  NUM_REQ*IDX_SIZE  flattened addresses; requester i occupies bits [i*IDX_SIZE +: IDX_SIZE]
req_write_data  input  NUM_REQ*WIDTH  flattened write data; same slicing scheme
req_read_data  output  WIDTH  registered read data, broadcast to all requesters; valid while req_done[i] is high
req_done  output  NUM_REQ  one-cycle completion pulse, one-hot
mem_addr0  output  IDX_SIZE  to memory addr0
mem_write_data  output  WIDTH  to memory write_data
mem_write_en  output  1  to memory write_en
mem_read_data  input  WIDTH  from memory read_data (combinational)
mem_done  input  1  from memory done

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- States: IDLE, ACCESS, WAIT_WR, DONE. Registers:
  - state
  - grant (log2 NUM_REQ bits)
  - last (previous winner)
  - rdata
  - req_done
- Reset values:
  - state=IDLE, grant=0, last=NUM_REQ-1 (so requester 0 has first priority)
  - rdata=0, req_done=0
  - mem_write_en=0 combinationally, because the state is IDLE
- Reset asserted in any state returns the block to IDLE on the next edge and abandons the in-flight access.
  - A write whose mem_write_en edge coincides with reset is suppressed by the memory's own reset gating.
- IDLE:
  - If any req_go bit is set, grant takes the first set index searching from last+1 upward, with wrap-around; go to ACCESS.
  - req_go is sampled only in IDLE.
- ACCESS:
  - mem_addr0 and mem_write_data are driven from the granted slice.
  - Write (req_write_en[grant]=1): mem_write_en=1 for exactly this cycle; go to WAIT_WR.
  - Read: rdata<=mem_read_data; go to DONE.
- WAIT_WR:
  - mem_write_en=0.
  - On mem_done=1, go to DONE; otherwise stay.
  - The memory asserts done one cycle after write_en, so WAIT_WR lasts 1 cycle.
- DONE:
  - req_done[grant]=1 for exactly one cycle.
  - req_read_data=rdata.
  - last<=grant; go to IDLE.
- mem_addr0 and mem_write_data are a combinational mux on grant in every state. mem_write_en is high only in ACCESS with a write.
- Latency, counting the first go-high edge in IDLE as cycle 0:
  - Read: done in cycle 2.
  - Write: done in cycle 3.
  - Throughput is one access per 3 (read) or 4 (write) cycles.
- Simultaneous requests: exactly one is granted. The others wait; no request is lost as long as its go stays high.
- Fairness: a requester that keeps go high after its done is a new request and loses priority to every other pending requester.
- Go withdrawn mid-transaction is a protocol error. The transaction still completes and done still pulses.
- req_read_data holds rdata at all times; it is only meaningful during done.

Optional Feature:
- Macro: COMB_MEM_D1_ARBITER_CHECKS_EN.
- When defined, simulation-only checks issue $error on:
  - req_go[grant] low in ACCESS or WAIT_WR (go withdrawn early)
  - the granted address >= SIZE in ACCESS
  - WAIT_WR lasting more than 4 cycles (memory done lost)
  - req_done not one-hot-or-zero
- When undefined, none of this logic exists. Functional behaviour is identical either way.

Decomposition:
- Package comb_mem_arb_pkg:
  - state enum typedef arb_state_e {IDLE, ACCESS, WAIT_WR, DONE}
  - function clog2_min1(n) for grant width
- Sub-module rr_pick:
  - Purely combinational.
  - Inputs: NUM_REQ request vector, last index.
  - Outputs: winner index and valid.
  - Reusable by future register-file arbiters.

Test Plan:
- Single read: mem[5]=0xDEADBEEF; req_go[0]=1, write_en=0, addr=5 -> req_done[0] in cycle 2, req_read_data=0xDEADBEEF, mem_write_en never high.
- Single write: req_go[1]=1, write_en=1, addr=3, data=0x1234 -> mem_write_en high for exactly 1 cycle, req_done[1] in cycle 3, subsequent read of addr 3 returns 0x1234.
- Contention: req_go[0] and req_go[1] held high from reset release, both reads -> done order 0,1,0,1…; no two done pulses within 3 cycles.
- Priority wrap with NUM_REQ=4: last=3, requests on 1 and 2 -> 1 served first, then 2, then 0 if it is raised meanwhile.
- Reset mid-write: assert reset in WAIT_WR -> next cycle state=IDLE, req_done=0, no done pulse for the aborted requester; a fresh request then completes normally.
- With COMB_MEM_D1_ARBITER_CHECKS_EN: drop req_go[0] during ACCESS -> exactly one $error; address 20 with SIZE=16 -> $error.
